// File: rtl/division_if.sv
// Start/done handshake bundle between a datapath controller (master) and the
// shared sequential divider (slave).
interface division_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Res;
  logic [WIDTH-1:0] Rem;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (
    output start, A, B,
    input  Res, Rem, busy, done, dz
  );

  modport slave (
    input  start, A, B,
    output Res, Rem, busy, done, dz
  );
endinterface

// File: rtl/division.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// start/done handshake, divide-by-zero flagged instead of computed.
module division #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  division_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_LAST = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] rem_reg;    // partial remainder
  logic [WIDTH-1:0] dvd_reg;    // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] div_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] rem_out_reg;
  logic             dz_reg;

  logic [WIDTH:0]   trial_top;
  logic [WIDTH:0]   trial_diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // rem < B keeps trial_top < 2B, so trial_top - B always fits in WIDTH+1
  // bits two's complement and the MSB is exactly the borrow.
  always_comb begin
    trial_top  = {rem_reg, dvd_reg[WIDTH-1]};
    trial_diff = trial_top - {1'b0, div_reg};
    borrow     = trial_diff[WIDTH];
    rem_next   = borrow ? trial_top[WIDTH-1:0] : trial_diff[WIDTH-1:0];
    quo_next   = {dvd_reg[WIDTH-2:0], ~borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      rem_reg     <= '0;
      dvd_reg     <= '0;
      div_reg     <= '0;
      count_reg   <= '0;
      res_reg     <= '0;
      rem_out_reg <= '0;
      dz_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            dvd_reg   <= bus.A;
            div_reg   <= bus.B;
            rem_reg   <= '0;
            count_reg <= COUNT_INIT;
            if (bus.B != '0) begin
              dz_reg    <= 1'b0;
              state_reg <= BUSY;
            end else begin
              dz_reg      <= 1'b1;
              res_reg     <= '1;
              rem_out_reg <= bus.A;
              state_reg   <= DONE;
            end
          end
        end
        BUSY: begin
          rem_reg   <= rem_next;
          dvd_reg   <= quo_next;
          count_reg <= count_reg - CW'(1);
          if (count_reg == COUNT_LAST) begin
            res_reg     <= quo_next;
            rem_out_reg <= rem_next;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.Res  = res_reg;
  assign bus.Rem  = rem_out_reg;
  assign bus.dz   = dz_reg;
  assign bus.done = (state_reg == DONE);
  assign bus.busy = (state_reg != IDLE);

endmodule

// File: tb/tb_division.sv
// Directed bench for the sequential divider: hand-computed vectors, boundary
// cases, reset behaviour, back-to-back starts and a short random run.
module tb_division;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  division_if #(.WIDTH(W)) bus ();

  division #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present the operands, let the next edge accept them,
  // then scramble A/B so a late change would corrupt the result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    bus.start = hold;
  endtask

  // Returns at the negedge on which done is seen (or after the cycle budget).
  task automatic wait_done(input string tag, input int exp_lat, input logic [W-1:0] exp_res,
                           input logic [W-1:0] exp_rem, input logic exp_dz);
    int lat;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (lat > 0) begin
      chk({tag, " Res"}, 32'(bus.Res), 32'(exp_res));
      chk({tag, " Rem"}, 32'(bus.Rem), 32'(exp_rem));
      chk({tag, " dz"}, 32'(bus.dz), 32'(exp_dz));
      chk({tag, " busy_in_done"}, 32'(bus.busy), 32'd1);
    end
    $display("[TB] %s: A/B -> Res=%0d Rem=%0d dz=%0d latency=%0d", tag, bus.Res, bus.Rem, bus.dz, lat);
  endtask

  task automatic check_after(input string tag);
    @(negedge clk);
    chk({tag, " done_pulse_ends"}, 32'(bus.done), 32'd0);
    chk({tag, " idle_after"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] exp_res, input logic [W-1:0] exp_rem, input logic exp_dz,
                    input bit hold);
    issue(a, b, hold);
    wait_done(tag, exp_dz ? 1 : W + 1, exp_res, exp_rem, exp_dz);
    check_after(tag);
  endtask

  initial begin
    int dones;
    logic [W-1:0] ra, rb;

    // Reset wins over a simultaneous start.
    bus.start = 1'b1;
    bus.A     = 8'd9;
    bus.B     = 8'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset Res", 32'(bus.Res), 32'd0);
    chk("reset Rem", 32'(bus.Rem), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset dz", 32'(bus.dz), 32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("post_reset idle", 32'(bus.busy), 32'd0);

    op("100/10", 8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 1'b0);
    op("200/40", 8'd200, 8'd40, 8'd5, 8'd0, 1'b0, 1'b0);
    op("90/9", 8'd90, 8'd9, 8'd10, 8'd0, 1'b0, 1'b1);
    op("70/10", 8'd70, 8'd10, 8'd7, 8'd0, 1'b0, 1'b0);
    op("16/3", 8'd16, 8'd3, 8'd5, 8'd1, 1'b0, 1'b1);
    op("255/5", 8'd255, 8'd5, 8'd51, 8'd0, 1'b0, 1'b0);
    op("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b0);
    op("0/7", 8'd0, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0);
    op("200/1", 8'd200, 8'd1, 8'd200, 8'd0, 1'b0, 1'b0);
    op("123/123", 8'd123, 8'd123, 8'd1, 8'd0, 1'b0, 1'b0);
    op("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0);
    op("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b0);
    op("255/16", 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 1'b0);
    op("1/255", 8'd1, 8'd255, 8'd0, 8'd1, 1'b0, 1'b0);
    op("42/0", 8'd42, 8'd0, 8'hFF, 8'd42, 1'b1, 1'b0);

    // Divide by zero, then a start raised in the DONE cycle: ignored there,
    // accepted on the following IDLE edge.
    issue(8'd0, 8'd0, 1'b0);
    wait_done("0/0", 1, 8'hFF, 8'd0, 1'b1);
    bus.start = 1'b1;
    bus.A     = 8'd7;
    bus.B     = 8'd2;
    @(negedge clk);
    chk("b2b ignored_in_done", 32'(bus.busy), 32'd0);
    chk("b2b done_cleared", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = 8'd250;
    bus.B     = 8'd250;
    wait_done("7/2 b2b", W + 1, 8'd3, 8'd1, 1'b0);
    check_after("7/2 b2b");

    // Reset in cycle 4 of an operation aborts it with no done pulse.
    issue(8'd100, 8'd10, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("abort no_done", 32'(dones), 32'd0);
    chk("abort Res", 32'(bus.Res), 32'd0);
    chk("abort Rem", 32'(bus.Rem), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort dz", 32'(bus.dz), 32'd0);
    op("16/3 after_abort", 8'd16, 8'd3, 8'd5, 8'd1, 1'b0, 1'b0);

    // Random operands with start held high through BUSY.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = (n % 8 == 3) ? 8'd0 : W'($urandom);
      if (rb == 0)
        op("rand", ra, rb, 8'hFF, ra, 1'b1, 1'b1);
      else
        op("rand", ra, rb, ra / rb, ra % rb, 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
